// File: rtl/transmitter_i2s.sv
// transmitter_i2s: byte-stream to I2S (Philips) master transmitter.
// Reassembles DATA_SIZE-bit samples from bytes (LSB byte first) and shifts
// them out MSB first with a one-bit delay after each word-select edge.
// Optional feature macro: I2S_TX_DUP_EN (duplicate left sample onto right word).
module transmitter_i2s #(
  parameter int unsigned DATA_SIZE = 24,
  parameter int unsigned CLK_DIV   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_data_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        i2s_clk,
  output logic        i2s_ws,
  output logic        i2s_sd,
  output logic        underrun_o,
  output logic [15:0] underrun_count_o
);

  localparam int unsigned NBYTES = DATA_SIZE / 8;
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SLOT_W = 6;

  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(NBYTES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST   = 6'd63;
  localparam logic [SLOT_W-1:0] LEFT_FIRST  = 6'd1;
  localparam logic [SLOT_W-1:0] LEFT_LAST   = SLOT_W'(DATA_SIZE);
`ifdef I2S_TX_DUP_EN
  localparam logic [SLOT_W-1:0] RIGHT_FIRST = 6'd33;
  localparam logic [SLOT_W-1:0] RIGHT_LAST  = SLOT_W'(32 + DATA_SIZE);
`endif

  // Assembler states
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]           state, state_d;
  logic [IDX_W-1:0]     idx, idx_d;
  logic [DATA_SIZE-1:0] sample;
  logic [DATA_SIZE-1:0] left_sh;
`ifdef I2S_TX_DUP_EN
  logic [DATA_SIZE-1:0] right_sh;
`endif
  logic [DIV_W-1:0]     div_cnt;
  logic [SLOT_W-1:0]    slot;
  logic [SLOT_W-1:0]    slot_next;
  logic                 div_wrap;
  logic                 sck_fall;
  logic                 frame_load;
  logic                 accept;
  logic                 in_left;
`ifdef I2S_TX_DUP_EN
  logic                 in_right;
`endif

  // Handshake and frame-timing decode
  assign byte_ready_o = (state == ST_FILL);
  assign accept       = byte_valid_i && byte_ready_o;
  assign div_wrap     = (div_cnt == DIV_LAST);
  assign sck_fall     = div_wrap && i2s_clk;
  assign slot_next    = SLOT_W'(slot + 6'd1);
  assign frame_load   = sck_fall && (slot == SLOT_LAST);
  assign in_left      = (slot_next >= LEFT_FIRST) && (slot_next <= LEFT_LAST);
`ifdef I2S_TX_DUP_EN
  assign in_right     = (slot_next >= RIGHT_FIRST) && (slot_next <= RIGHT_LAST);
`endif

  // Assembler state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FILL;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  // Assembler next state: fill bytes, hold until the next frame load takes the sample
  always_comb begin
    state_d = state;
    idx_d   = idx;
    case (state)
      ST_FILL: begin
        if (accept) begin
          if (idx == IDX_LAST) begin
            state_d = ST_HOLD;
            idx_d   = '0;
          end else begin
            idx_d = IDX_W'(idx + 1'b1);
          end
        end
      end
      ST_HOLD: begin
        if (frame_load) begin
          state_d = ST_FILL;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_FILL;
        idx_d   = '0;
      end
    endcase
  end

  // Sample buffer: accepted byte lands in its byte lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample <= '0;
    end else if (accept) begin
      sample[{idx, 3'b000} +: 8] <= byte_data_i;
    end
  end

  // Bit-clock divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      i2s_clk <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      i2s_clk <= ~i2s_clk;
    end else begin
      div_cnt <= DIV_W'(div_cnt + 1'b1);
    end
  end

  // Slot counter, word select and serial data; all change on the bit-clock falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot     <= SLOT_LAST;
      i2s_ws   <= 1'b1;
      i2s_sd   <= 1'b0;
      left_sh  <= '0;
`ifdef I2S_TX_DUP_EN
      right_sh <= '0;
`endif
    end else if (sck_fall) begin
      slot   <= slot_next;
      i2s_ws <= slot_next[5];
      i2s_sd <= 1'b0;
      if (frame_load) begin
        left_sh  <= (state == ST_HOLD) ? sample : '0;
`ifdef I2S_TX_DUP_EN
        right_sh <= (state == ST_HOLD) ? sample : '0;
`endif
      end else if (in_left) begin
        i2s_sd  <= left_sh[DATA_SIZE-1];
        left_sh <= {left_sh[DATA_SIZE-2:0], 1'b0};
      end
`ifdef I2S_TX_DUP_EN
      else if (in_right) begin
        i2s_sd   <= right_sh[DATA_SIZE-1];
        right_sh <= {right_sh[DATA_SIZE-2:0], 1'b0};
      end
`endif
    end
  end

  // Underrun pulse and saturating counter: frame started without a complete sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_o       <= 1'b0;
      underrun_count_o <= '0;
    end else begin
      underrun_o <= frame_load && (state != ST_HOLD);
      if (frame_load && (state != ST_HOLD) && (underrun_count_o != 16'hFFFF)) begin
        underrun_count_o <= 16'(underrun_count_o + 16'd1);
      end
    end
  end

endmodule

// File: tb/tb_transmitter_i2s.sv
// tb_transmitter_i2s: randomized/directed bench with a frame-level reference
// model; expected frames and underrun counts are queued by the stimulus side
// and consumed by an independent monitor sampling on the DAC's bit-clock edge.
module tb_transmitter_i2s;

  localparam int unsigned DS    = 24;
  localparam int unsigned CD    = 4;
  localparam int unsigned NB    = DS / 8;
  localparam int unsigned FRAME = 128 * CD;
  localparam int unsigned FIRST = 2 * CD - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready_o;
  logic        i2s_clk;
  logic        i2s_ws;
  logic        i2s_sd;
  logic        underrun_o;
  logic [15:0] underrun_count_o;

  transmitter_i2s #(.DATA_SIZE(DS), .CLK_DIV(CD)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .byte_data_i      (byte_data),
    .byte_valid_i     (byte_valid),
    .byte_ready_o     (byte_ready_o),
    .i2s_clk          (i2s_clk),
    .i2s_ws           (i2s_ws),
    .i2s_sd           (i2s_sd),
    .underrun_o       (underrun_o),
    .underrun_count_o (underrun_count_o)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int frames_checked = 0;

  // Reference model state
  int          nb;
  int          k;
  int          nbnd;
  bit          last_acc;
  logic [23:0] asm_s;
  logic [15:0] ucnt;
  logic [63:0] exp_frames[$];
  logic [15:0] exp_urun[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected slot-by-slot data of one frame for a given sample (bit s = slot s)
  function automatic logic [63:0] frame_of(input logic [23:0] s);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < int'(DS); i++) begin
      f[1 + i] = s[DS - 1 - i];
`ifdef I2S_TX_DUP_EN
      f[33 + i] = s[DS - 1 - i];
`endif
    end
    return f;
  endfunction

  function automatic bit edge_is_boundary(input int e);
    return (e >= int'(FIRST)) && (((e - int'(FIRST)) % int'(FRAME)) == 0);
  endfunction

  // One clk cycle of stimulus plus model update; entered and left just after a falling edge
  task automatic cyc(input bit v, input logic [7:0] d);
    bit rdy_m;
    bit acc;
    byte_valid = v;
    byte_data  = d;
    #1;
    rdy_m = (nb < int'(NB));
    check("byte_ready", 64'(byte_ready_o), 64'(rdy_m));
    check("i2s_clk", 64'(i2s_clk), 64'((k / int'(CD)) % 2));
    acc = v && rdy_m;
    @(posedge clk);
    if (edge_is_boundary(k)) begin
      nbnd++;
      if (nb == int'(NB)) begin
        exp_frames.push_back(frame_of(asm_s));
        nb = 0;
      end else begin
        exp_frames.push_back(64'd0);
        if (ucnt != 16'hFFFF) ucnt = ucnt + 16'd1;
        exp_urun.push_back(ucnt);
      end
    end
    if (acc) begin
      asm_s[8*nb +: 8] = d;
      nb++;
    end
    last_acc = acc;
    k++;
    @(negedge clk);
  endtask

  task automatic idle_frames(input int n);
    int target;
    target = nbnd + n;
    while (nbnd < target) cyc(1'b0, 8'h00);
  endtask

  task automatic run_to_phase(input int ph);
    int guard;
    guard = 0;
    while (!((k >= int'(FIRST)) && (((k - int'(FIRST)) % int'(FRAME)) == ph)) && guard < 2 * int'(FRAME)) begin
      cyc(1'b0, 8'h00);
      guard++;
    end
  endtask

  task automatic model_reset();
    nb = 0; k = 0; ucnt = '0; asm_s = '0; last_acc = 1'b0;
    exp_frames.delete();
    exp_urun.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_clk"},   64'(i2s_clk), 64'd0);
    check({tag, "_ws"},    64'(i2s_ws), 64'd1);
    check({tag, "_sd"},    64'(i2s_sd), 64'd0);
    check({tag, "_ready"}, 64'(byte_ready_o), 64'd1);
    check({tag, "_urun"},  64'(underrun_o), 64'd0);
    check({tag, "_ucnt"},  64'(underrun_count_o), 64'd0);
  endtask

  // Monitor: captures (ws, sd) on every bit-clock rising edge and checks whole frames
  initial begin
    bit          prev_sck;
    bit          prev_ws;
    bit          in_frame;
    int          idx;
    logic [63:0] ws_bits;
    logic [63:0] sd_bits;
    logic [63:0] e;
    logic [15:0] u;
    prev_sck = 1'b0; prev_ws = 1'b1; in_frame = 1'b0; idx = 0;
    ws_bits = '0; sd_bits = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_sck = 1'b0; prev_ws = 1'b1; in_frame = 1'b0; idx = 0;
      end else begin
        if (underrun_o) begin
          if (exp_urun.size() == 0) begin
            check("unexpected_underrun", 64'd1, 64'd0);
          end else begin
            u = exp_urun.pop_front();
            check("underrun_count", 64'(underrun_count_o), 64'(u));
          end
        end
        if (i2s_clk && !prev_sck) begin
          if (prev_ws && !i2s_ws) begin
            in_frame = 1'b1;
            idx = 0;
          end
          if (in_frame) begin
            ws_bits[idx] = i2s_ws;
            sd_bits[idx] = i2s_sd;
            idx++;
            if (idx == 64) begin
              in_frame = 1'b0;
              idx = 0;
              frames_checked++;
              check("frame_ws", ws_bits, 64'hFFFF_FFFF_0000_0000);
              if (exp_frames.size() == 0) begin
                check("unexpected_frame", 64'd1, 64'd0);
              end else begin
                e = exp_frames.pop_front();
                check("frame_sd", sd_bits, e);
              end
            end
          end
          prev_ws = i2s_ws;
        end
        prev_sck = i2s_clk;
      end
    end
  end

  // Watchdog
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    logic [7:0] six[6];
    int i;
    int guard;
    six[0] = 8'h11; six[1] = 8'h22; six[2] = 8'h33;
    six[3] = 8'hC4; six[4] = 8'hB5; six[5] = 8'hA6;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    rst_n      = 1'b0;
    nbnd       = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed sample, then three empty frames
    cyc(1'b1, 8'hAA);
    cyc(1'b1, 8'h66);
    cyc(1'b1, 8'hFF);
    idle_frames(4);
    check("ucnt_after_3", 64'(underrun_count_o), 64'd3);

    // Back-to-back samples with valid held high
    i = 0;
    guard = 0;
    while (i < 6 && guard < 3 * int'(FRAME)) begin
      cyc(1'b1, six[i]);
      if (last_acc) i++;
      guard++;
    end
    check("six_bytes_accepted", 64'(i), 64'd6);
    idle_frames(2);

    // Last byte accepted in the frame-load cycle
    cyc(1'b1, 8'h5A);
    cyc(1'b1, 8'h3C);
    guard = 0;
    while (!edge_is_boundary(k) && guard < 2 * int'(FRAME)) begin
      cyc(1'b0, 8'h00);
      guard++;
    end
    cyc(1'b1, 8'h81);
    idle_frames(2);

    // Randomized byte arrival
    for (int c = 0; c < 8 * int'(FRAME); c++) begin
      cyc($urandom_range(0, 999) < 6, 8'($urandom));
    end

    // Saturation of the underrun counter
    idle_frames(1);
    run_to_phase(10);
    force dut.underrun_count_o = 16'hFFFE;
    ucnt = 16'hFFFE;
    cyc(1'b0, 8'h00);
    release dut.underrun_count_o;
    idle_frames(3);
    check("ucnt_saturated", 64'(underrun_count_o), 64'hFFFF);

    // Reset in the middle of a frame with a partial sample pending
    run_to_phase(int'(FRAME) / 3);
    cyc(1'b1, 8'hE7);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    while (k < int'(FIRST)) cyc(1'b0, 8'h00);
    check("ws_before_first_fall", 64'(i2s_ws), 64'd1);
    check("clk_before_first_fall", 64'(i2s_clk), 64'd1);
    cyc(1'b1, 8'h0F);
    check("ws_after_first_fall", 64'(i2s_ws), 64'd0);
    check("clk_after_first_fall", 64'(i2s_clk), 64'd0);
    cyc(1'b1, 8'hF0);
    cyc(1'b1, 8'h99);
    idle_frames(2);

    check("underruns_drained", 64'(exp_urun.size()), 64'd0);
    check("frames_drained", 64'(exp_frames.size() <= 1), 64'd1);
    check("frames_seen", 64'(frames_checked >= 20), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
